cpu_serial_link: RTL and testbench



---
 rtl/cpu_serial_link.sv | 220 ++++++++++++++++++++++
 tb/tb_cpu_serial_link.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_serial_link.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cpu_serial_link
//  Description : Frames typed CPU messages onto an IO_BITS-wide tx pin bus
//                (start / type / data) and deframes response words from an
//                IO_BITS-wide rx pin bus into a held, acknowledged register
//                with sticky overrun detection. Optional pin-side registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_serial_link #(
    parameter int IO_BITS   = 2,
    parameter int WORD_BITS = 16,
    parameter int REG_IO    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [1:0]           tx_type,
    input  logic [WORD_BITS-1:0] tx_data,
    output logic [IO_BITS-1:0]   tx_pins,
    output logic                 tx_fetch,
    output logic                 tx_jump,
    input  logic [IO_BITS-1:0]   rx_pins,
    output logic                 rx_valid,
    output logic [WORD_BITS-1:0] rx_data,
    input  logic                 rx_ack,
    output logic                 rx_overrun
);

    // Chunks per word, and header cycles needed to carry the 2-bit type.
    localparam int N     = WORD_BITS / IO_BITS;
    localparam int H     = (IO_BITS == 1) ? 2 : 1;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H - 1);

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_TYPE  = 2'd2,
        TX_DATA  = 2'd3
    } tx_state_t;

    typedef enum logic [0:0] {
        RX_IDLE = 1'b0,
        RX_DATA = 1'b1
    } rx_state_t;

    tx_state_t            tx_state;
    logic [CNT_W-1:0]     tx_cnt;
    logic [1:0]           tx_type_q;
    logic [WORD_BITS-1:0] tx_shift;
    logic [IO_BITS-1:0]   pins_int;
    logic                 fetch_int;
    logic                 jump_int;

    rx_state_t            rx_state;
    logic [CNT_W-1:0]     rx_cnt;
    logic [IO_BITS-1:0]   rx_sample;
    logic [WORD_BITS-1:0] rx_word;
    logic                 rx_complete;

    assign tx_ready = (tx_state == TX_IDLE);

    // TX framer: pin value and type flags are registered alongside the state,
    // so each one always shows the value belonging to the current state.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_type_q <= 2'd0;
            tx_shift  <= '0;
            pins_int  <= '1;
            fetch_int <= 1'b0;
            jump_int  <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_valid) begin
                        tx_state  <= TX_START;
                        tx_type_q <= tx_type;
                        tx_shift  <= tx_data;
                        tx_cnt    <= '0;
                        pins_int  <= '0;
                        fetch_int <= (tx_type == 2'd2);
                        jump_int  <= (tx_type == 2'd3);
                    end
                end
                TX_START: begin
                    tx_state <= TX_TYPE;
                    tx_cnt   <= '0;
                    pins_int <= IO_BITS'(tx_type_q);
                end
                TX_TYPE: begin
                    if (tx_cnt == H_LAST) begin
                        tx_state <= TX_DATA;
                        tx_cnt   <= '0;
                        pins_int <= tx_shift[IO_BITS-1:0];
                        tx_shift <= tx_shift >> IO_BITS;
                    end else begin
                        // Only reached with a 1-bit bus: second type bit.
                        tx_cnt   <= tx_cnt + CNT_W'(1);
                        pins_int <= IO_BITS'(tx_type_q[1]);
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == N_LAST) begin
                        tx_state  <= TX_IDLE;
                        pins_int  <= '1;
                        fetch_int <= 1'b0;
                        jump_int  <= 1'b0;
                    end else begin
                        tx_cnt   <= tx_cnt + CNT_W'(1);
                        pins_int <= tx_shift[IO_BITS-1:0];
                        tx_shift <= tx_shift >> IO_BITS;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    generate
        if (REG_IO != 0) begin : g_reg_io
            logic [IO_BITS-1:0] pins_q;
            logic [IO_BITS-1:0] rx_q;
            logic               fetch_q;
            logic               jump_q;

            // Pin-side registers; both idle high so reset never fakes a start.
            always_ff @(posedge clk) begin
                if (reset) begin
                    pins_q  <= '1;
                    fetch_q <= 1'b0;
                    jump_q  <= 1'b0;
                    rx_q    <= '1;
                end else begin
                    pins_q  <= pins_int;
                    fetch_q <= fetch_int;
                    jump_q  <= jump_int;
                    rx_q    <= rx_pins;
                end
            end

            assign tx_pins   = pins_q;
            assign tx_fetch  = fetch_q;
            assign tx_jump   = jump_q;
            assign rx_sample = rx_q;
        end else begin : g_no_reg_io
            assign tx_pins   = pins_int;
            assign tx_fetch  = fetch_int;
            assign tx_jump   = jump_int;
            assign rx_sample = rx_pins;
        end
    endgenerate

    // Incoming chunks enter at the top so the first (LSB) chunk ends lowest.
    generate
        if (N > 1) begin : g_rx_shift
            logic [WORD_BITS-IO_BITS-1:0] rx_shift;

            // Accumulate chunks only while deframing a word.
            always_ff @(posedge clk) begin
                if (reset) begin
                    rx_shift <= '0;
                end else if (rx_state == RX_DATA) begin
                    rx_shift <= rx_word[WORD_BITS-1:IO_BITS];
                end
            end

            assign rx_word = {rx_sample, rx_shift};
        end else begin : g_rx_single
            assign rx_word = rx_sample;
        end
    endgenerate

    assign rx_complete = (rx_state == RX_DATA) && (rx_cnt == N_LAST);

    // RX deframer plus holding register with acknowledge and sticky overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            rx_overrun <= 1'b0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_sample[0]) begin
                        rx_state <= RX_DATA;
                        rx_cnt   <= '0;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == N_LAST) begin
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase

            if (rx_complete) begin
                rx_data  <= rx_word;
                rx_valid <= 1'b1;
                if (rx_valid && !rx_ack) begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_serial_link.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_serial_link
//  Description : Directed bench for cpu_serial_link; instance A uses a 2-bit
//                bus, 16-bit words and pin registers, instance B a 1-bit bus,
//                8-bit words and no pin registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_serial_link;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    logic        a_tx_valid, a_tx_ready, a_tx_fetch, a_tx_jump;
    logic [1:0]  a_tx_type, a_tx_pins, a_rx_pins;
    logic [15:0] a_tx_data, a_rx_data;
    logic        a_rx_valid, a_rx_ack, a_rx_overrun;

    logic        b_tx_valid, b_tx_ready, b_tx_fetch, b_tx_jump;
    logic [1:0]  b_tx_type;
    logic [0:0]  b_tx_pins, b_rx_pins;
    logic [7:0]  b_tx_data, b_rx_data;
    logic        b_rx_valid, b_rx_ack, b_rx_overrun;

    cpu_serial_link #(.IO_BITS(2), .WORD_BITS(16), .REG_IO(1)) dut_a (
        .clk(clk), .reset(reset),
        .tx_valid(a_tx_valid), .tx_ready(a_tx_ready), .tx_type(a_tx_type),
        .tx_data(a_tx_data), .tx_pins(a_tx_pins), .tx_fetch(a_tx_fetch),
        .tx_jump(a_tx_jump), .rx_pins(a_rx_pins), .rx_valid(a_rx_valid),
        .rx_data(a_rx_data), .rx_ack(a_rx_ack), .rx_overrun(a_rx_overrun)
    );

    cpu_serial_link #(.IO_BITS(1), .WORD_BITS(8), .REG_IO(0)) dut_b (
        .clk(clk), .reset(reset),
        .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .tx_type(b_tx_type),
        .tx_data(b_tx_data), .tx_pins(b_tx_pins), .tx_fetch(b_tx_fetch),
        .tx_jump(b_tx_jump), .rx_pins(b_rx_pins), .rx_valid(b_rx_valid),
        .rx_data(b_rx_data), .rx_ack(b_rx_ack), .rx_overrun(b_rx_overrun)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        valid;
        logic [1:0]  typ;
        logic [15:0] data;
        logic [1:0]  pins;
        logic        ready;
        logic        fetch;
        logic        jump;
    } tx_vec_t;

    tx_vec_t vec [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Drive start chunk then the eight 2-bit chunks of w, LSB first.
    task automatic a_send(input logic [15:0] w);
        a_rx_pins = 2'b00;
        tick();
        for (int k = 0; k < 8; k++) begin
            a_rx_pins = w[k*2 +: 2];
            tick();
        end
        a_rx_pins = 2'b11;
    endtask

    logic [1:0]  pins_log [23];
    logic        jump_log [23];
    logic [11:0] b_tx_seq;
    logic [8:0]  b_rx_seq;
    int          idle_cnt;

    initial begin
        reset = 1'b1;
        a_tx_valid = 1'b0; a_tx_type = 2'd0; a_tx_data = 16'h0;
        a_rx_pins = 2'b11; a_rx_ack = 1'b0;
        b_tx_valid = 1'b0; b_tx_type = 2'd0; b_tx_data = 8'h0;
        b_rx_pins = 1'b1; b_rx_ack = 1'b0;

        // FETCH A5C3: chunks LSB first are 11,00,00,11,01,01,10,10.
        // Row 5 offers a JUMP mid-frame which must be ignored.
        vec[0]  = '{1'b1, 2'd2, 16'hA5C3, 2'b11, 1'b0, 1'b0, 1'b0};
        vec[1]  = '{1'b0, 2'd0, 16'h0000, 2'b00, 1'b0, 1'b1, 1'b0};
        vec[2]  = '{1'b0, 2'd0, 16'h0000, 2'b10, 1'b0, 1'b1, 1'b0};
        vec[3]  = '{1'b0, 2'd0, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b0};
        vec[4]  = '{1'b0, 2'd0, 16'h0000, 2'b00, 1'b0, 1'b1, 1'b0};
        vec[5]  = '{1'b1, 2'd3, 16'h0000, 2'b00, 1'b0, 1'b1, 1'b0};
        vec[6]  = '{1'b0, 2'd0, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b0};
        vec[7]  = '{1'b0, 2'd0, 16'h0000, 2'b01, 1'b0, 1'b1, 1'b0};
        vec[8]  = '{1'b0, 2'd0, 16'h0000, 2'b01, 1'b0, 1'b1, 1'b0};
        vec[9]  = '{1'b0, 2'd0, 16'h0000, 2'b10, 1'b0, 1'b1, 1'b0};
        vec[10] = '{1'b0, 2'd0, 16'h0000, 2'b10, 1'b1, 1'b1, 1'b0};
        vec[11] = '{1'b0, 2'd0, 16'h0000, 2'b11, 1'b1, 1'b0, 1'b0};

        // Reset state on the first post-reset cycle.
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_tx_pins", 32'(a_tx_pins), 32'h3);
        chk("rst_tx_ready", 32'(a_tx_ready), 32'h1);
        chk("rst_tx_fetch", 32'(a_tx_fetch), 32'h0);
        chk("rst_tx_jump", 32'(a_tx_jump), 32'h0);
        chk("rst_rx_valid", 32'(a_rx_valid), 32'h0);
        chk("rst_rx_data", 32'(a_rx_data), 32'h0);
        chk("rst_rx_overrun", 32'(a_rx_overrun), 32'h0);

        // Table-driven FETCH frame.
        for (int i = 0; i < 12; i++) begin
            a_tx_valid = vec[i].valid;
            a_tx_type  = vec[i].typ;
            a_tx_data  = vec[i].data;
            tick();
            chk($sformatf("fetch_pins[%0d]", i), 32'(a_tx_pins), 32'(vec[i].pins));
            chk($sformatf("fetch_ready[%0d]", i), 32'(a_tx_ready), 32'(vec[i].ready));
            chk($sformatf("fetch_flag[%0d]", i), 32'(a_tx_fetch), 32'(vec[i].fetch));
            chk($sformatf("fetch_jump[%0d]", i), 32'(a_tx_jump), 32'(vec[i].jump));
        end
        a_tx_valid = 1'b0;
        tick();

        // Two JUMP frames with tx_valid held: exactly one idle cycle between.
        a_tx_valid = 1'b1;
        a_tx_type  = 2'd3;
        a_tx_data  = 16'h0000;
        for (int i = 0; i < 23; i++) begin
            tick();
            pins_log[i] = a_tx_pins;
            jump_log[i] = a_tx_jump;
            if (i == 12) a_tx_valid = 1'b0;
        end
        idle_cnt = 0;
        for (int i = 1; i < 22; i++) begin
            if (pins_log[i] == 2'b11 && !jump_log[i]) idle_cnt++;
        end
        chk("jump_idle_count", 32'(idle_cnt), 32'd1);
        chk("jump_first_start", {30'd0, pins_log[1]}, 32'h0);
        chk("jump_first_flag", 32'(jump_log[1]), 32'h1);
        chk("jump_gap_pins", {30'd0, pins_log[11]}, 32'h3);
        chk("jump_gap_flag", 32'(jump_log[11]), 32'h0);
        chk("jump_second_start", {30'd0, pins_log[12]}, 32'h0);
        chk("jump_second_flag", 32'(jump_log[12]), 32'h1);
        chk("jump_end_pins", {30'd0, pins_log[22]}, 32'h3);
        chk("jump_end_flag", 32'(jump_log[22]), 32'h0);

        // 1-bit bus: WRITE 0x81 on tx while rx receives start + 0x81.
        b_tx_seq   = 12'hC0A;
        b_rx_seq   = 9'h102;
        b_tx_type  = 2'd1;
        b_tx_data  = 8'h81;
        for (int i = 0; i < 12; i++) begin
            b_tx_valid = (i == 0);
            b_rx_pins  = (i < 9) ? b_rx_seq[i] : 1'b1;
            tick();
            chk($sformatf("b_tx_pins[%0d]", i), 32'(b_tx_pins), 32'(b_tx_seq[i]));
            chk($sformatf("b_tx_ready[%0d]", i), 32'(b_tx_ready), (i >= 11) ? 32'h1 : 32'h0);
            if (i == 7) chk("b_rx_valid_early", 32'(b_rx_valid), 32'h0);
            if (i == 8) begin
                chk("b_rx_valid", 32'(b_rx_valid), 32'h1);
                chk("b_rx_data", 32'(b_rx_data), 32'h81);
            end
        end
        b_tx_valid = 1'b0;

        // Mid-frame reset aborts TX and a partial RX word.
        a_tx_valid = 1'b1;
        a_tx_type  = 2'd2;
        a_tx_data  = 16'h1234;
        a_rx_pins  = 2'b00;
        tick();
        a_tx_valid = 1'b0;
        a_rx_pins  = 2'b01;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("midrst_tx_pins", 32'(a_tx_pins), 32'h3);
        chk("midrst_tx_ready", 32'(a_tx_ready), 32'h1);
        chk("midrst_tx_fetch", 32'(a_tx_fetch), 32'h0);
        reset = 1'b0;
        a_rx_pins = 2'b11;
        for (int i = 0; i < 12; i++) tick();
        chk("midrst_rx_valid", 32'(a_rx_valid), 32'h0);

        // Receive 0x1234, then acknowledge.
        a_send(16'h1234);
        chk("rx_valid_before", 32'(a_rx_valid), 32'h0);
        tick();
        chk("rx_valid_after", 32'(a_rx_valid), 32'h1);
        chk("rx_data_1234", 32'(a_rx_data), 32'h1234);
        a_rx_ack = 1'b1;
        tick();
        a_rx_ack = 1'b0;
        chk("rx_ack_clears", 32'(a_rx_valid), 32'h0);
        chk("rx_no_overrun", 32'(a_rx_overrun), 32'h0);

        // Back-to-back words without ack: overwrite and sticky overrun.
        a_send(16'h0001);
        a_send(16'h0002);
        tick();
        chk("ovr_rx_valid", 32'(a_rx_valid), 32'h1);
        chk("ovr_rx_data", 32'(a_rx_data), 32'h0002);
        chk("ovr_flag", 32'(a_rx_overrun), 32'h1);
        a_rx_ack = 1'b1;
        tick();
        a_rx_ack = 1'b0;
        chk("ovr_sticky", 32'(a_rx_overrun), 32'h1);

        // Ack coinciding with completion: no overrun.
        do_reset();
        tick();
        a_send(16'h0001);
        tick();
        chk("ackc_first_valid", 32'(a_rx_valid), 32'h1);
        a_send(16'h0002);
        a_rx_ack = 1'b1;
        tick();
        a_rx_ack = 1'b0;
        chk("ackc_rx_valid", 32'(a_rx_valid), 32'h1);
        chk("ackc_rx_data", 32'(a_rx_data), 32'h0002);
        chk("ackc_no_overrun", 32'(a_rx_overrun), 32'h0);
        a_rx_ack = 1'b1;
        tick();
        a_rx_ack = 1'b0;
        chk("ackc_cleared", 32'(a_rx_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
